hilo_muldiv: RTL

Parametrised HI/LO unit for the datapath. It holds the HI and LO registers and adds an iterative multiply/divide engine that writes its double-width result into them. Direct writes to HI and LO from the register-write path remain available. A busy flag tells the control unit to stall while an operation is in flight.

---
 rtl/hilo_pkg.sv | 17 +
 rtl/hilo_muldiv_regs.sv | 31 +++
 rtl/hilo_muldiv.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/hilo_pkg.sv
// Shared types for the HI/LO multiply/divide unit: operation encoding and FSM states.
package hilo_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10
    } hilo_state_e;

endpackage

// File: rtl/hilo_muldiv_regs.sv
// HI/LO architectural register pair, written on the falling edge like the register file.
module hilo_regs #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we_hi,
    input  logic             we_lo,
    input  logic [WIDTH-1:0] d_hi,
    input  logic [WIDTH-1:0] d_lo,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic [WIDTH-1:0] hi_reg;
    logic [WIDTH-1:0] lo_reg;

    always_ff @(negedge clk) begin
        if (!rst_n) begin
            hi_reg <= '0;
            lo_reg <= '0;
        end else begin
            if (we_hi) hi_reg <= d_hi;
            if (we_lo) lo_reg <= d_lo;
        end
    end

    assign hi = hi_reg;
    assign lo = lo_reg;

endmodule

// File: rtl/hilo_muldiv.sv
// HI/LO unit with an iterative shift-add multiplier and restoring divider.
// Operands run as magnitudes; the sign is reapplied in FIX before commit.
module hilo_muldiv
    import hilo_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             wehi,
    input  logic             welo,
    input  logic [WIDTH-1:0] wd,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    hilo_state_e      state_reg, state_next;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH:0]   acc_hi_reg;   // partial product high half / remainder
    logic [WIDTH-1:0] acc_lo_reg;   // multiplier bits / dividend-then-quotient
    logic [WIDTH-1:0] opb_reg;
    logic             is_div_reg, neg_q_reg, neg_r_reg, dz_reg;
    logic             done_reg, dbz_reg;

    muldiv_op_e       op_e;
    logic             op_is_div, op_signed, neg_a, neg_b, b_zero, accept;
    logic [WIDTH-1:0] mag_a, mag_b;

    assign op_e      = muldiv_op_e'(op);
    assign op_is_div = (op_e == OP_DIV) || (op_e == OP_DIVU);
    assign op_signed = SIGNED_EN && ((op_e == OP_MULT) || (op_e == OP_DIV));
    assign neg_a     = op_signed && a[WIDTH-1];
    assign neg_b     = op_signed && b[WIDTH-1];
    assign mag_a     = neg_a ? (~a + 1'b1) : a;
    assign mag_b     = neg_b ? (~b + 1'b1) : b;
    assign b_zero    = (b == '0);
    assign accept    = (state_reg == IDLE) && start;

    // One iteration of each engine.
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_sh;
    logic [WIDTH-1:0] div_diff;
    logic             div_ge;

    assign mul_sum  = acc_lo_reg[0] ? (acc_hi_reg + {1'b0, opb_reg}) : acc_hi_reg;
    assign div_sh   = {acc_hi_reg[WIDTH-1:0], acc_lo_reg[WIDTH-1]};
    assign div_ge   = (div_sh >= {1'b0, opb_reg});
    assign div_diff = div_sh[WIDTH-1:0] - opb_reg;

    // Sign correction of the finished magnitude result.
    logic [2*WIDTH-1:0] prod_mag, prod_fix;
    logic [WIDTH-1:0]   res_hi, res_lo;

    assign prod_mag = {acc_hi_reg[WIDTH-1:0], acc_lo_reg};
    assign prod_fix = neg_q_reg ? (~prod_mag + 1'b1) : prod_mag;

    always_comb begin
        res_hi = prod_fix[2*WIDTH-1:WIDTH];
        res_lo = prod_fix[WIDTH-1:0];
        if (dz_reg) begin
            res_hi = acc_hi_reg[WIDTH-1:0];
            res_lo = acc_lo_reg;
        end else if (is_div_reg) begin
            res_lo = neg_q_reg ? (~acc_lo_reg + 1'b1) : acc_lo_reg;
            res_hi = neg_r_reg ? (~acc_hi_reg[WIDTH-1:0] + 1'b1) : acc_hi_reg[WIDTH-1:0];
        end
    end

    always_ff @(negedge clk) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (start) state_next = (op_is_div && b_zero) ? FIX : RUN;
            RUN:  if (cnt_reg == CW'(1)) state_next = FIX;
            FIX:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(negedge clk) begin
        if (!rst_n) begin
            cnt_reg    <= '0;
            acc_hi_reg <= '0;
            acc_lo_reg <= '0;
            opb_reg    <= '0;
            is_div_reg <= 1'b0;
            neg_q_reg  <= 1'b0;
            neg_r_reg  <= 1'b0;
            dz_reg     <= 1'b0;
            done_reg   <= 1'b0;
            dbz_reg    <= 1'b0;
        end else begin
            done_reg <= (state_reg == FIX);
            dbz_reg  <= (state_reg == FIX) && dz_reg;
            if (accept) begin
                cnt_reg    <= CW'(WIDTH);
                is_div_reg <= op_is_div;
                opb_reg    <= mag_b;
                if (op_is_div && b_zero) begin
                    // Divide by zero skips the engine: HI gets the raw dividend.
                    acc_hi_reg <= {1'b0, a};
                    acc_lo_reg <= '1;
                    dz_reg     <= 1'b1;
                    neg_q_reg  <= 1'b0;
                    neg_r_reg  <= 1'b0;
                end else begin
                    acc_hi_reg <= '0;
                    acc_lo_reg <= mag_a;
                    dz_reg     <= 1'b0;
                    neg_q_reg  <= neg_a ^ neg_b;
                    neg_r_reg  <= neg_a;
                end
            end else if (state_reg == RUN) begin
                cnt_reg <= cnt_reg - 1'b1;
                if (is_div_reg) begin
                    acc_hi_reg <= {1'b0, (div_ge ? div_diff : div_sh[WIDTH-1:0])};
                    acc_lo_reg <= {acc_lo_reg[WIDTH-2:0], div_ge};
                end else begin
                    acc_hi_reg <= {1'b0, mul_sum[WIDTH:1]};
                    acc_lo_reg <= {mul_sum[0], acc_lo_reg[WIDTH-1:1]};
                end
            end
        end
    end

    // Engine commit wins in FIX; direct writes only when idle and not starting.
    logic             we_hi, we_lo, direct_ok;
    logic [WIDTH-1:0] d_hi, d_lo;

    assign direct_ok = (state_reg == IDLE) && !start;
    assign we_hi     = (state_reg == FIX) || (direct_ok && wehi);
    assign we_lo     = (state_reg == FIX) || (direct_ok && welo);
    assign d_hi      = (state_reg == FIX) ? res_hi : wd;
    assign d_lo      = (state_reg == FIX) ? res_lo : wd;

    hilo_regs #(.WIDTH(WIDTH)) u_regs (
        .clk   (clk),
        .rst_n (rst_n),
        .we_hi (we_hi),
        .we_lo (we_lo),
        .d_hi  (d_hi),
        .d_lo  (d_lo),
        .hi    (hi),
        .lo    (lo)
    );

    assign busy        = (state_reg != IDLE);
    assign done        = done_reg;
    assign div_by_zero = dbz_reg;

endmodule
